// File: rtl/pkt_asm_pkg.sv
// Shared types and default configuration for the packet assembler.
// The state encoding is visible to anything that imports this package.
package pkt_asm_pkg;

   localparam int PKT_ASM_BYTE_W      = 8;
   localparam int PKT_ASM_PKT_BYTES   = 32;
   localparam int PKT_ASM_TIMEOUT_CYC = 1024;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_HOLD = 2'd2
   } pkt_state_e;

endpackage : pkt_asm_pkg

// File: rtl/pkt_assembler.sv
// Packs bytes popped from a first-word-fall-through FIFO into a wide packet,
// LSB- or MSB-lane first, closing early on flush or after an idle timeout.
module pkt_assembler
   import pkt_asm_pkg::*;
#(
   parameter int BYTE_W      = PKT_ASM_BYTE_W,
   parameter int PKT_BYTES   = PKT_ASM_PKT_BYTES,
   parameter int TIMEOUT_CYC = PKT_ASM_TIMEOUT_CYC,
   localparam int CNT_W      = $clog2(PKT_BYTES + 1)
)(
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_fifo_empty,
   input  logic [BYTE_W-1:0]           i_fifo_data,
   output logic                        o_fifo_rd_en,
   input  logic                        i_msb_first,
   input  logic                        i_flush,
   output logic [BYTE_W*PKT_BYTES-1:0] o_packet,
   output logic [CNT_W-1:0]            o_pkt_len,
   output logic                        o_pkt_partial,
   output logic                        o_pkt_valid,
   input  logic                        i_pkt_ready
);

   localparam int IDLE_W     = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam bit TIMEOUT_EN = (TIMEOUT_CYC > 0);
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(PKT_BYTES - 1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(PKT_BYTES);

   pkt_state_e                  state_q,   state_d;
   logic [CNT_W-1:0]            cnt_q,     cnt_d;
   logic [IDLE_W-1:0]           idle_q,    idle_d;
   logic [BYTE_W*PKT_BYTES-1:0] packet_q,  packet_d;
   logic                        partial_q, partial_d;
   logic                        msb_q,     msb_d;
   logic                        valid_q,   valid_d;

   logic                        rd_en_s;
   logic                        mode_s;
   logic [CNT_W-1:0]            lane_s;
   logic [CNT_W-1:0]            cnt_inc_s;
   logic                        full_s;
   logic [IDLE_W-1:0]           idle_inc_s;
   logic                        timeout_s;

   // Gating with i_rst_n keeps the FIFO untouched while reset is held.
   assign rd_en_s      = i_rst_n && !i_fifo_empty && (state_q != ST_HOLD);
   assign o_fifo_rd_en = rd_en_s;

   assign o_packet      = packet_q;
   assign o_pkt_len     = cnt_q;
   assign o_pkt_partial = partial_q;
   assign o_pkt_valid   = valid_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idle_d    = idle_q;
      packet_d  = packet_q;
      partial_d = partial_q;
      msb_d     = msb_q;

      // The first byte of a packet samples the mode live; later bytes use the latched copy.
      mode_s     = (state_q == ST_IDLE) ? i_msb_first : msb_q;
      lane_s     = mode_s ? (LAST_LANE - cnt_q) : cnt_q;
      cnt_inc_s  = cnt_q + CNT_W'(rd_en_s);
      full_s     = (cnt_inc_s == FULL_CNT);
      idle_inc_s = idle_q + IDLE_W'(1);
      timeout_s  = TIMEOUT_EN && !rd_en_s && (idle_inc_s == IDLE_W'(TIMEOUT_CYC));

      for (int i = 0; i < PKT_BYTES; i++) begin
         if (rd_en_s && (lane_s == CNT_W'(i))) begin
            packet_d[i*BYTE_W +: BYTE_W] = i_fifo_data;
         end else begin
            packet_d[i*BYTE_W +: BYTE_W] = packet_d[i*BYTE_W +: BYTE_W];
         end
      end

      case (state_q)
         ST_IDLE: begin
            idle_d    = '0;
            partial_d = 1'b0;
            if (rd_en_s) begin
               cnt_d   = cnt_inc_s;
               msb_d   = i_msb_first;
               state_d = full_s ? ST_HOLD : ST_FILL;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FILL: begin
            cnt_d = cnt_inc_s;
            if (rd_en_s) begin
               idle_d = '0;
            end else if (TIMEOUT_EN) begin
               idle_d = idle_inc_s;
            end else begin
               idle_d = idle_q;
            end
            // A completing byte wins over a simultaneous flush or timeout.
            if (full_s) begin
               state_d   = ST_HOLD;
               partial_d = 1'b0;
            end else if (i_flush || timeout_s) begin
               state_d   = ST_HOLD;
               partial_d = 1'b1;
            end else begin
               state_d = ST_FILL;
            end
         end
         ST_HOLD: begin
            idle_d = '0;
            if (valid_q && i_pkt_ready) begin
               state_d   = ST_IDLE;
               cnt_d     = '0;
               packet_d  = '0;
               partial_d = 1'b0;
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            idle_d    = '0;
            packet_d  = '0;
            partial_d = 1'b0;
            msb_d     = 1'b0;
         end
      endcase

      valid_d = (state_d == ST_HOLD);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         idle_q    <= '0;
         packet_q  <= '0;
         partial_q <= 1'b0;
         msb_q     <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idle_q    <= idle_d;
         packet_q  <= packet_d;
         partial_q <= partial_d;
         msb_q     <= msb_d;
         valid_q   <= valid_d;
      end
   end

endmodule : pkt_assembler

// File: doc/pkt_assembler.md
PKT_ASSEMBLER -- requirements
Module: pkt_assembler

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
- BYTE_W, 8, width of one input byte lane.
- PKT_BYTES, 32, bytes per full packet.
- TIMEOUT_CYC, 1024, idle cycles in FILL before a partial packet is forced; 0 disables the timeout.
REQ-002 CNT_W SHALL be a derived localparam equal to clog2(PKT_BYTES+1).
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning:
- i_clk, in, 1, sole clock.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_fifo_empty, in, 1, FIFO has no data (first-word-fall-through: i_fifo_data is valid whenever this is 0).
- i_fifo_data, in, BYTE_W, FIFO head byte.
- o_fifo_rd_en, out, 1, pops the FIFO head this cycle.
- i_msb_first, in, 1, byte-order mode.
- i_flush, in, 1, close the current partial packet.
- o_packet, out, BYTE_W*PKT_BYTES, assembled packet.
- o_pkt_len, out, CNT_W, number of valid bytes in o_packet.
- o_pkt_partial, out, 1, packet closed before reaching PKT_BYTES bytes.
- o_pkt_valid, out, 1, packet available.
- i_pkt_ready, in, 1, consumer accepts the packet.
REQ-004 The block SHALL use one clock (i_clk); reset (i_rst_n) SHALL be asynchronous and active-low.

Function
REQ-005 The state machine SHALL have states IDLE (0 bytes held), FILL (1..PKT_BYTES-1 bytes held) and HOLD (packet presented).
REQ-006 o_fifo_rd_en SHALL equal !i_fifo_empty && state!=HOLD; every cycle o_fifo_rd_en=1 SHALL accept exactly one byte.
REQ-007 Byte k of a packet (k=0 first accepted) SHALL be placed at lane k, bits [k*BYTE_W +: BYTE_W], when the packet's mode is LSB-first.
REQ-008 When the packet's mode is MSB-first, byte k SHALL be placed at lane PKT_BYTES-1-k.
REQ-009 The packet's mode SHALL be i_msb_first sampled on the cycle the packet's first byte is accepted, and SHALL be held constant for the rest of that packet.
REQ-010 Unfilled lanes SHALL read zero; a partial packet's bytes SHALL NOT be repacked.
REQ-011 IDLE SHALL go to FILL on an accepted byte.
REQ-012 A byte accepted while holding PKT_BYTES-1 bytes SHALL move the block to HOLD with o_pkt_len=PKT_BYTES and o_pkt_partial=0.
REQ-013 With PKT_BYTES=1, IDLE SHALL go directly to HOLD on an accepted byte.
REQ-014 i_flush in FILL SHALL move the block to HOLD with o_pkt_len equal to the current count, including any byte accepted that same cycle, and o_pkt_partial=1.
REQ-015 If a flush coincides with the byte that completes the packet, the result SHALL be a full packet with o_pkt_partial=0.
REQ-016 i_flush SHALL be ignored in IDLE and in HOLD.
REQ-017 The idle counter SHALL count consecutive FILL cycles with no accepted byte and SHALL clear on every accepted byte and on entry to FILL.
REQ-018 When TIMEOUT_CYC>0 and the idle counter reaches TIMEOUT_CYC, the block SHALL behave as a flush.
REQ-019 o_pkt_valid SHALL be registered and asserted exactly while the block is in HOLD.
REQ-020 o_packet, o_pkt_len and o_pkt_partial SHALL be stable while o_pkt_valid=1.
REQ-021 HOLD SHALL go to IDLE on the cycle o_pkt_valid && i_pkt_ready, clearing the lanes and the count.
REQ-022 Latency SHALL be: the final byte accepted at edge N gives o_pkt_valid=1 after edge N; the next pop is possible in the cycle after the handshake (one-cycle bubble).

Reset
REQ-023 Assertion of i_rst_n=0 SHALL immediately force state=IDLE, count=0, idle counter=0, o_packet=0, o_pkt_len=0, o_pkt_partial=0 and o_pkt_valid=0.
REQ-024 While reset is asserted, o_fifo_rd_en SHALL be 0.
REQ-025 A reset asserted mid-packet or during HOLD SHALL discard the held bytes with no packet emitted.

Structure
REQ-026 Package pkt_asm_pkg SHALL hold the state enum (IDLE/FILL/HOLD) and the default parameter constants.
REQ-027 The block SHALL be a single module with no sub-module; the idle timer is inline.

Verification
REQ-028 Configuration for all scenarios SHALL be BYTE_W=8, PKT_BYTES=32, TIMEOUT_CYC=64, with i_pkt_ready=1 unless stated.
REQ-029 The bench SHALL cover these scenarios:
- Push bytes 0x00..0x1F, LSB-first -> one packet, lane i=i, len=32, partial=0.
- Push 0xFF..0xE0 with i_msb_first=1 -> lane 31=0xFF, lane 0=0xE0.
- Push 5 bytes 0xA0..0xA4, then assert i_flush together with the 5th byte -> len=5, partial=1, lanes 5..31=0.
- Push 3 bytes, then starve the FIFO -> o_pkt_valid rises on the 65th idle cycle with len=3, partial=1.
- Complete a packet, hold i_pkt_ready=0 for 10 cycles with the FIFO non-empty -> o_fifo_rd_en=0 and o_packet stable throughout; after ready, the next packet's bytes start at lane 0.
- Assert reset after 17 bytes, release it, then push 32 bytes -> exactly one packet, with no residue from the first 17 bytes.
